// File: rtl/irq_source_agent.sv
// Per-line 4-phase IRQ/EOI requester with queued events and a 2-flop eoi synchronizer.
// Optional REQ-dwell timeout is built only when IRQ_AGENT_TIMEOUT_EN is defined.
module irq_source_agent #(
   parameter int unsigned N_IRQ     = 16,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned TO_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] trig,
   input  logic [N_IRQ-1:0] eoi,
   output logic [N_IRQ-1:0] irq,
   output logic [N_IRQ-1:0] done,
   output logic [N_IRQ-1:0] ovf,
   output logic [N_IRQ-1:0] timeout,
   input  logic [N_IRQ-1:0] clr
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_REL
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (TO_CYCLES < 2) begin : g_to_cycles_range
      $error("irq_source_agent: TO_CYCLES must be >= 2");
   end

   logic [N_IRQ-1:0] eoi_m_q, eoi_m_d;
   logic [N_IRQ-1:0] eoi_s_q, eoi_s_d;
   logic [N_IRQ-1:0] irq_q, irq_d;
   logic [N_IRQ-1:0] done_q, done_d;
   logic [N_IRQ-1:0] ovf_q, ovf_d;
   logic [N_IRQ-1:0] timeout_q, timeout_d;
   logic [N_IRQ-1:0] launch;
   logic [N_IRQ-1:0] ovf_set;
   logic [N_IRQ-1:0] to_set;
   state_e           state_q [N_IRQ];
   state_e           state_d [N_IRQ];
   logic [CNT_W-1:0] cnt_q   [N_IRQ];
   logic [CNT_W-1:0] cnt_d   [N_IRQ];

`ifdef IRQ_AGENT_TIMEOUT_EN
   localparam int unsigned       DW_W    = $clog2(TO_CYCLES);
   localparam logic [DW_W-1:0]   DW_LAST = DW_W'(TO_CYCLES - 1);
   logic [DW_W-1:0] dwell_q [N_IRQ];
   logic [DW_W-1:0] dwell_d [N_IRQ];
`endif

   always_comb begin
      eoi_m_d = eoi;
      eoi_s_d = eoi_m_q;
      done_d  = '0;
      launch  = '0;
      ovf_set = '0;
      to_set  = '0;
      irq_d   = '0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef IRQ_AGENT_TIMEOUT_EN
         dwell_d[i] = '0;
`endif
         case (state_q[i])
            ST_IDLE: begin
               // eoi_s is deliberately ignored here
               if (cnt_q[i] != '0 || trig[i]) begin
                  state_d[i] = ST_REQ;
                  launch[i]  = 1'b1;
               end
            end
            ST_REQ: begin
               if (eoi_s_q[i]) begin
                  state_d[i] = ST_REL;
               end
`ifdef IRQ_AGENT_TIMEOUT_EN
               else if (dwell_q[i] == DW_LAST) begin
                  state_d[i] = ST_REL;
                  to_set[i]  = 1'b1;
               end else begin
                  dwell_d[i] = dwell_q[i] + 1'b1;
               end
`endif
            end
            ST_REL: begin
               if (!eoi_s_q[i]) begin
                  state_d[i] = ST_IDLE;
                  done_d[i]  = 1'b1;
               end
            end
            default: state_d[i] = ST_IDLE;
         endcase

         // A launch consumes the event the same cycle's trig would add
         if (trig[i] && !launch[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_set[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (launch[i] && !trig[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end

         irq_d[i] = (state_d[i] == ST_REQ);
      end
      ovf_d = (ovf_q & ~clr) | ovf_set;
`ifdef IRQ_AGENT_TIMEOUT_EN
      timeout_d = (timeout_q & ~clr) | to_set;
`else
      timeout_d = '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eoi_m_q   <= '0;
         eoi_s_q   <= '0;
         irq_q     <= '0;
         done_q    <= '0;
         ovf_q     <= '0;
         timeout_q <= '0;
         for (int unsigned i = 0; i < N_IRQ; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
`ifdef IRQ_AGENT_TIMEOUT_EN
            dwell_q[i] <= '0;
`endif
         end
      end else begin
         eoi_m_q   <= eoi_m_d;
         eoi_s_q   <= eoi_s_d;
         irq_q     <= irq_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         timeout_q <= timeout_d;
         for (int unsigned i = 0; i < N_IRQ; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
`ifdef IRQ_AGENT_TIMEOUT_EN
            dwell_q[i] <= dwell_d[i];
`endif
         end
      end
   end

   assign irq     = irq_q;
   assign done    = done_q;
   assign ovf     = ovf_q;
   assign timeout = timeout_q;

endmodule
